// File: rtl/perf_pkg.sv
// Shared state encoding and readout-select convention for the pipeline performance monitor.
package perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } perf_state_e;

    localparam int DRAIN_W = 8;

    // The cycle counter sits directly after the last event channel in the readout map.
    function automatic int cycle_sel(input int n_evt);
        return n_evt;
    endfunction

endpackage

// File: rtl/perf_counter.sv
// Single event/cycle counter with synchronous clear and sticky overflow flag.
// Define PERF_SAT_EN to saturate at the maximum value instead of wrapping.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // Next count and overflow: clear wins, then increment with wrap or saturation.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr) begin
            cnt_d = {CNT_W{1'b0}};
            ovf_d = 1'b0;
        end else if (inc) begin
            if (cnt_q == {CNT_W{1'b1}}) begin
                ovf_d = 1'b1;
`ifdef PERF_SAT_EN
                cnt_d = cnt_q;
`else
                cnt_d = {CNT_W{1'b0}};
`endif
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter and overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_event_monitor.sv
// Event/cycle counting monitor with start/drain/freeze run control and registered readout.
// Define PERF_SAT_EN to make all counters saturate instead of wrapping.
module perf_event_monitor
    import perf_pkg::*;
#(
    parameter int N_EVT    = 4,
    parameter int CNT_W    = 32,
    parameter int HALT_DLY = 1,
    parameter int SEL_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clr_i,
    input  logic [N_EVT-1:0] evt_i,
    input  logic             done_i,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic [N_EVT:0]   ovf_o,
    output logic [1:0]       state_o,
    output logic             done_o
);

    localparam int CYCLE_SEL = cycle_sel(N_EVT);

    perf_state_e        state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0]   rd_data_q, rd_data_d;
    logic               done_q, done_d;
    logic               count_en_s;
    logic [N_EVT:0]     inc_s;
    logic [N_EVT:0]     ovf_s;
    logic [CNT_W-1:0]   cnt_s [0:N_EVT];

    assign count_en_s             = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign inc_s[N_EVT-1:0]       = evt_i & {N_EVT{count_en_s}};
    assign inc_s[CYCLE_SEL]       = count_en_s;

    generate
        for (genvar g = 0; g <= N_EVT; g++) begin : g_cnt
            perf_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clr_i),
                .inc   (inc_s[g]),
                .cnt_o (cnt_s[g]),
                .ovf_o (ovf_s[g])
            );
        end
    endgenerate

    // Run-control next state and drain countdown; clear overrides everything.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        if (clr_i) begin
            state_d = ST_IDLE;
            drain_d = {DRAIN_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) state_d = ST_RUN;
                    else       state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (!done_i) begin
                        state_d = ST_RUN;
                    end else if (HALT_DLY == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_W'(HALT_DLY);
                    end
                end
                ST_DRAIN: begin
                    drain_d = drain_q - DRAIN_W'(1);
                    // A zero drain count cannot normally occur here; treat it as expired.
                    if (drain_q <= DRAIN_W'(1)) state_d = ST_DONE;
                    else                        state_d = ST_DRAIN;
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
        done_d = (state_d == ST_DONE);
    end

    // Readout mux: event channels, then the cycle counter, zero beyond.
    always_comb begin
        rd_data_d = {CNT_W{1'b0}};
        for (int i = 0; i <= N_EVT; i++) begin
            rd_data_d = rd_data_d | (cnt_s[i] & {CNT_W{rd_sel == SEL_W'(i)}});
        end
    end

    // Control and readout registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            drain_q   <= {DRAIN_W{1'b0}};
            rd_data_q <= {CNT_W{1'b0}};
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            rd_data_q <= rd_data_d;
            done_q    <= done_d;
        end
    end

    assign state_o = state_q;
    assign done_o  = done_q;
    assign rd_data = rd_data_q;
    assign ovf_o   = ovf_s;

endmodule

// File: tb/tb_perf_event_monitor.sv
// Self-checking bench: two monitors (32-bit/drain 1 and 4-bit/drain 0) share stimulus and a count model.
module tb_perf_event_monitor;

    localparam int N_EVT = 4;
    localparam int SEL_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, clr_i, done_i;
    logic [N_EVT-1:0] evt_i;
    logic [SEL_W-1:0] rd_sel;

    logic [31:0]    rd_a;
    logic [3:0]     rd_b;
    logic [N_EVT:0] ovf_a, ovf_b;
    logic [1:0]     st_a, st_b;
    logic           dn_a, dn_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    perf_event_monitor #(.N_EVT(N_EVT), .CNT_W(32), .HALT_DLY(1), .SEL_W(SEL_W)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .clr_i(clr_i), .evt_i(evt_i),
        .done_i(done_i), .rd_sel(rd_sel), .rd_data(rd_a), .ovf_o(ovf_a),
        .state_o(st_a), .done_o(dn_a));

    perf_event_monitor #(.N_EVT(N_EVT), .CNT_W(4), .HALT_DLY(0), .SEL_W(SEL_W)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .clr_i(clr_i), .evt_i(evt_i),
        .done_i(done_i), .rd_sel(rd_sel), .rd_data(rd_b), .ovf_o(ovf_b),
        .state_o(st_b), .done_o(dn_b));

    // Reference model: true (unbounded) counts per instance, phase 0..3 as published on state_o.
    longint cnt_m [2][N_EVT+1];
    int     phase_m [2];
    int     left_m [2];
    longint rd_m [2];

    function automatic int width_of(input int inst);
        return (inst == 0) ? 32 : 4;
    endfunction

    function automatic int hdly_of(input int inst);
        return (inst == 0) ? 1 : 0;
    endfunction

    function automatic longint shown(input int inst, input longint v);
        longint mx;
        mx = (longint'(1) << width_of(inst)) - 1;
`ifdef PERF_SAT_EN
        return (v > mx) ? mx : v;
`else
        return v & mx;
`endif
    endfunction

    function automatic longint exp_ovf(input int inst);
        longint r = 0;
        longint mx = (longint'(1) << width_of(inst)) - 1;
        for (int k = 0; k <= N_EVT; k++)
            if (cnt_m[inst][k] > mx) r = r | (longint'(1) << k);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k <= N_EVT; k++) cnt_m[i][k] = 0;
            phase_m[i] = 0;
            left_m[i]  = 0;
            rd_m[i]    = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            rd_m[i] = (int'(rd_sel) <= N_EVT) ? shown(i, cnt_m[i][rd_sel]) : 0;
            if (clr_i) begin
                for (int k = 0; k <= N_EVT; k++) cnt_m[i][k] = 0;
                phase_m[i] = 0;
                left_m[i]  = 0;
            end else begin
                if (phase_m[i] == 1 || phase_m[i] == 2) begin
                    cnt_m[i][N_EVT]++;
                    for (int k = 0; k < N_EVT; k++) cnt_m[i][k] += longint'(evt_i[k]);
                end
                if (phase_m[i] == 0 && start) begin
                    phase_m[i] = 1;
                end else if (phase_m[i] == 1 && done_i) begin
                    if (hdly_of(i) == 0) phase_m[i] = 3;
                    else begin
                        phase_m[i] = 2;
                        left_m[i]  = hdly_of(i);
                    end
                end else if (phase_m[i] == 2) begin
                    left_m[i]--;
                    if (left_m[i] == 0) phase_m[i] = 3;
                end
            end
        end
    endtask

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        check("state_a", longint'(st_a), longint'(phase_m[0]));
        check("state_b", longint'(st_b), longint'(phase_m[1]));
        check("done_a", longint'(dn_a), longint'(phase_m[0] == 3));
        check("done_b", longint'(dn_b), longint'(phase_m[1] == 3));
        check("ovf_a", longint'(ovf_a), exp_ovf(0));
        check("ovf_b", longint'(ovf_b), exp_ovf(1));
        check("rd_a", longint'(rd_a), rd_m[0]);
        check("rd_b", longint'(rd_b), rd_m[1]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd_a"}, longint'(rd_a), 0);
        check({tag, "_rd_b"}, longint'(rd_b), 0);
        check({tag, "_ovf_a"}, longint'(ovf_a), 0);
        check({tag, "_ovf_b"}, longint'(ovf_b), 0);
        check({tag, "_st_a"}, longint'(st_a), 0);
        check({tag, "_st_b"}, longint'(st_b), 0);
        check({tag, "_dn_a"}, longint'(dn_a), 0);
        check({tag, "_dn_b"}, longint'(dn_b), 0);
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    typedef struct {
        logic        start;
        logic        clr;
        logic        done;
        logic [3:0]  evt;
        logic [4:0]  sel;
        logic [1:0]  exp_st;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [29];

    initial begin
        // Directed table for instance A: start, 20 RUN cycles, done on cycle 20, one drain cycle, readout.
        for (int i = 0; i < 29; i++) begin
            tbl[i] = '{start: 1'b0, clr: 1'b0, done: 1'b0, evt: 4'd0, sel: 5'd0,
                       exp_st: 2'd3, chk_rd: 1'b0, exp_rd: 32'd0};
            if (i <= 19) tbl[i].exp_st = 2'd1;
            if (i == 20) tbl[i].exp_st = 2'd2;
        end
        tbl[0].start = 1'b1;
        tbl[2].evt = 4'b0001;  tbl[5].evt = 4'b0001;  tbl[9].evt = 4'b0001;
        tbl[3].evt = 4'b0010;  tbl[4].evt = 4'b0010;  tbl[10].evt = 4'b0010;
        tbl[11].evt = 4'b0010; tbl[15].evt = 4'b0010;
        tbl[20].done = 1'b1;
        tbl[21].evt = 4'b0011;
        tbl[22].sel = 5'd0;  tbl[22].chk_rd = 1'b1; tbl[22].exp_rd = 32'd4;
        tbl[23].sel = 5'd1;  tbl[23].chk_rd = 1'b1; tbl[23].exp_rd = 32'd6;
        tbl[24].sel = 5'd4;  tbl[24].chk_rd = 1'b1; tbl[24].exp_rd = 32'd21;
        tbl[25].sel = 5'd5;  tbl[25].chk_rd = 1'b1; tbl[25].exp_rd = 32'd0;
        tbl[26].sel = 5'd31; tbl[26].chk_rd = 1'b1; tbl[26].exp_rd = 32'd0;
        tbl[26].start = 1'b1; tbl[26].done = 1'b1;
        tbl[27].sel = 5'd2;  tbl[27].chk_rd = 1'b1; tbl[27].exp_rd = 32'd0;
        tbl[27].evt = 4'b1111; tbl[27].done = 1'b1; tbl[27].start = 1'b1;
        tbl[28].sel = 5'd4;  tbl[28].chk_rd = 1'b1; tbl[28].exp_rd = 32'd21;

        rst_n = 1'b0; start = 1'b0; clr_i = 1'b0; done_i = 1'b0;
        evt_i = 4'd0; rd_sel = 5'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 29; i++) begin
            start = tbl[i].start; clr_i = tbl[i].clr; done_i = tbl[i].done;
            evt_i = tbl[i].evt;   rd_sel = tbl[i].sel;
            step();
            check($sformatf("tbl%0d_state", i), longint'(st_a), longint'(tbl[i].exp_st));
            if (tbl[i].chk_rd)
                check($sformatf("tbl%0d_rd", i), longint'(rd_a), longint'(tbl[i].exp_rd));
        end
        start = 1'b0; done_i = 1'b0; evt_i = 4'd0;

        // Clear and start together in DONE: clear wins, then start arms.
        clr_i = 1'b1; start = 1'b1;
        step();
        check("prio_state", longint'(st_a), 0);
        check("prio_ovf_b", longint'(ovf_b), 0);
        clr_i = 1'b0;
        step();
        check("prio_rearm", longint'(st_a), 1);
        start = 1'b0;

        // Overflow: evt[2] for 17 RUN cycles on the 4-bit instance.
        clr_i = 1'b1; step(); clr_i = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        evt_i = 4'b0100; rd_sel = 5'd2;
        repeat (17) step();
        evt_i = 4'd0; done_i = 1'b1;
        step();
        done_i = 1'b0;
`ifdef PERF_SAT_EN
        check("ovf_cnt_b", longint'(rd_b), 15);
`else
        check("ovf_cnt_b", longint'(rd_b), 1);
`endif
        check("ovf_bit2_b", longint'(ovf_b[2]), 1);
        check("ovf_cyc_b", longint'(ovf_b[N_EVT]), 1);
        check("ovf_cnt_a", longint'(rd_a), 17);
        rd_sel = 5'd4;
        step();
        step();

        // Asynchronous reset in the middle of a run.
        clr_i = 1'b1; step(); clr_i = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        evt_i = 4'b0001;
        repeat (10) step();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_zero("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        evt_i = 4'd0;
        step();

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            clr_i  = ($urandom % 60) == 0;
            start  = ($urandom % 4) == 0;
            done_i = ($urandom % 30) == 0;
            evt_i  = 4'($urandom);
            rd_sel = (($urandom % 5) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
